// File: rtl/core_pkg.sv
// Shared core types and constants for the vector unit's memory-side datapath.
// Holds the VRF word type plus the narrower memory beat type used by the store serializer.
package core_pkg;

  localparam int unsigned VrfDataWidth  = 64;
  localparam int unsigned MemBeatWidth  = 32;
  localparam int unsigned StoreBufDepth = 4;

  typedef logic [VrfDataWidth-1:0] vrf_data_t;
  typedef logic [MemBeatWidth-1:0] mem_beat_t;

  // Counter width for n states, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset and flush.
// Full/empty use an extra pointer MSB, so all Depth entries are usable.
module sync_fifo #(
  parameter int unsigned Depth = 4,
  parameter type         data_t = logic [63:0]
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  flush_i,
  input  logic  push_i,
  input  data_t wdata_i,
  input  logic  pop_i,
  output data_t rdata_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0] rd_ptr_q, rd_ptr_d;
  data_t         mem_q [Depth];
  logic          push_en;
  logic          pop_en;

  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_en = push_i && !full_o && !flush_i;
  assign pop_en  = pop_i && !empty_o && !flush_i;
  assign rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/store_op_serializer.sv
// Buffers VRF store words from rvv_core and serializes each into MemWidth beats with a last marker.
// Optional macro STORE_OP_SERIALIZER_PERF_EN adds stall_cycles_o / words_done_o counters.
module store_op_serializer
  import core_pkg::*;
#(
  parameter int unsigned Depth    = StoreBufDepth,
  parameter int unsigned MemWidth = MemBeatWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    store_op_valid_i,
  input  logic [VrfDataWidth-1:0] store_op_i,
  output logic                    store_op_gnt_o,
  output logic                    mem_valid_o,
  output logic [MemWidth-1:0]     mem_data_o,
  output logic                    mem_last_o,
  input  logic                    mem_ready_i
`ifdef STORE_OP_SERIALIZER_PERF_EN
  ,
  output logic [31:0]             stall_cycles_o,
  output logic [31:0]             words_done_o
`endif
);

  localparam int unsigned NumBeats = VrfDataWidth / MemWidth;
  localparam int unsigned BeatCntW = cnt_width(NumBeats);

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("store_op_serializer: Depth must be a power of two >= 2");
  end
  if (MemWidth == 0 || (VrfDataWidth % MemWidth) != 0) begin : g_bad_width
    $error("store_op_serializer: MemWidth must divide VrfDataWidth");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                state_q, state_d;
  vrf_data_t             shreg_q, shreg_d;
  logic [BeatCntW-1:0]   beat_cnt_q, beat_cnt_d;
  logic                  rst_hold_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  vrf_data_t             fifo_rdata;
  logic                  beat_last;

  // Grant stays low for the reset cycle and the one after it.
  assign store_op_gnt_o = store_op_valid_i && !fifo_full && !flush_i && !rst_i && !rst_hold_q;

  sync_fifo #(
    .Depth  (Depth),
    .data_t (vrf_data_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (store_op_gnt_o),
    .wdata_i (store_op_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign beat_last   = (beat_cnt_q == BeatCntW'(NumBeats - 1));
  assign mem_valid_o = (state_q == SEND) && !rst_i;
  assign mem_last_o  = mem_valid_o && beat_last;
  assign mem_data_o  = mem_valid_o ? shreg_q[MemWidth-1:0] : '0;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    beat_cnt_d = beat_cnt_q;
    fifo_pop   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shreg_d    = fifo_rdata;
          beat_cnt_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (mem_ready_i) begin
          if (!beat_last) begin
            shreg_d    = shreg_q >> MemWidth;
            beat_cnt_d = beat_cnt_q + 1'b1;
          end else if (!fifo_empty) begin
            // Back-to-back words: reload without an idle bubble.
            fifo_pop   = 1'b1;
            shreg_d    = fifo_rdata;
            beat_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over any pop; a beat handshaked this cycle is still delivered.
    if (flush_i) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
      fifo_pop   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    rst_hold_q <= rst_i;
  end

`ifdef STORE_OP_SERIALIZER_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] words_cnt_q, words_cnt_d;

  // Saturating counters; flush leaves them untouched.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    words_cnt_d = words_cnt_q;
    if (mem_valid_o && !mem_ready_i && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (mem_valid_o && mem_ready_i && mem_last_o && (words_cnt_q != '1)) words_cnt_d = words_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      words_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      words_cnt_q <= words_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign words_done_o   = words_cnt_q;
`endif

endmodule

// File: tb/tb_store_op_serializer.sv
// Scoreboard bench for store_op_serializer: stimulus pushes expected beats, a monitor pops and compares.
// Build with +define+STORE_OP_SERIALIZER_PERF_EN to also exercise the performance counters.
module tb_store_op_serializer;
  import core_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        valid;
  logic [63:0] word;
  logic        gnt;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        mem_last;
  logic        mem_ready;
`ifdef STORE_OP_SERIALIZER_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] words_done;
`endif

  beat_t exp_q[$];
  beat_t exp_b;
  int    vectors     = 0;
  int    miscompares = 0;
  int    cyc         = 0;
  int    beats_seen  = 0;
  int    first_cyc   = -1;
  int    last_cyc    = -1;

  store_op_serializer dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .store_op_valid_i (valid),
    .store_op_i       (word),
    .store_op_gnt_o   (gnt),
    .mem_valid_o      (mem_valid),
    .mem_data_o       (mem_data),
    .mem_last_o       (mem_last),
    .mem_ready_i      (mem_ready)
`ifdef STORE_OP_SERIALIZER_PERF_EN
    ,
    .stall_cycles_o   (stall_cycles),
    .words_done_o     (words_done)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: outputs are stable at the falling edge; a handshake seen here completes at the next rise.
  always @(negedge clk) begin
    if (mem_valid === 1'b1 && mem_ready === 1'b1) begin
      beats_seen++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat", mem_data, mem_last);
      end else begin
        exp_b = exp_q.pop_front();
        check("beat_data", 64'(mem_data), 64'(exp_b.data));
        check("beat_last", 64'(mem_last), 64'(exp_b.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] w);
    exp_q.push_back('{data: w[31:0],  last: 1'b0});
    exp_q.push_back('{data: w[63:32], last: 1'b1});
  endtask

  // Offer one word for one cycle; expected beats are queued only when it is granted.
  task automatic offer(input logic [63:0] w, input bit record, output bit granted);
    valid = 1'b1;
    word  = w;
    @(negedge clk);
    granted = gnt;
    if (granted && record) push_exp(w);
    tick();
    valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d beats outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) tick();
  endtask

  task automatic do_reset(input string name);
    rst   = 1'b1;
    flush = 1'b0;
    valid = 1'b1;
    word  = 64'hDEAD_BEEF_0BAD_F00D;
    exp_q.delete();
    @(negedge clk);
    check({name, "_gnt"},   64'(gnt),       64'd0);
    check({name, "_valid"}, 64'(mem_valid), 64'd0);
    check({name, "_data"},  64'(mem_data),  64'd0);
    check({name, "_last"},  64'(mem_last),  64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check({name, "_after_gnt"},   64'(gnt),       64'd0);
    check({name, "_after_valid"}, 64'(mem_valid), 64'd0);
    check({name, "_after_data"},  64'(mem_data),  64'd0);
    tick();
    valid = 1'b0;
  endtask

  task automatic single_word(input string name, input logic [63:0] w);
    bit g;
    mem_ready = 1'b1;
    offer(w, 1'b1, g);
    check({name, "_gnt"}, 64'(g), 64'd1);
    @(negedge clk);
    check({name, "_t1_valid"}, 64'(mem_valid), 64'd0);
    tick();
    @(negedge clk);
    check({name, "_t2_valid"}, 64'(mem_valid), 64'd1);
    check({name, "_t2_data"},  64'(mem_data),  64'(w[31:0]));
    check({name, "_t2_last"},  64'(mem_last),  64'd0);
    tick();
    @(negedge clk);
    check({name, "_t3_data"},  64'(mem_data),  64'(w[63:32]));
    check({name, "_t3_last"},  64'(mem_last),  64'd1);
    tick();
    @(negedge clk);
    check({name, "_t4_valid"}, 64'(mem_valid), 64'd0);
    tick();
  endtask

  initial begin
    bit g;
    int idx;
    int grants;
    int n;
    logic [63:0] wa, wd, w6;

    rst       = 1'b1;
    flush     = 1'b0;
    valid     = 1'b0;
    word      = '0;
    mem_ready = 1'b0;

    do_reset("rst");

    // Single word with immediate ready.
    single_word("single", 64'h1111_2222_3333_4444);

    // Continuous stream of 8 words: 16 beats on consecutive cycles.
    mem_ready  = 1'b1;
    beats_seen = 0;
    first_cyc  = -1;
    idx = 0;
    n   = 0;
    while (idx < 8 && n < 200) begin
      offer({32'hC000_0000 | 32'(idx), 32'(idx)}, 1'b1, g);
      if (g) idx++;
      n++;
    end
    check("stream_words_granted", 64'(idx), 64'd8);
    drain("stream", 100);
    check("stream_beats", 64'(beats_seen), 64'd16);
    check("stream_no_bubble", 64'(last_cyc - first_cyc), 64'd15);

    // Backpressure: 4 in FIFO plus 1 in the shift register, word 6 refused.
    mem_ready = 1'b0;
    idx    = 1;
    grants = 0;
    for (int c = 0; c < 14; c++) begin
      if (idx <= 6) begin
        offer({32'hB000_0000 | 32'(idx), 32'h0000_0010 | 32'(idx)}, 1'b1, g);
        if (g) begin
          grants++;
          idx++;
        end
      end else begin
        tick();
      end
    end
    check("bp_grants", 64'(grants), 64'd5);
    check("bp_refused_idx", 64'(idx), 64'd6);
    w6 = {32'hB000_0006, 32'h0000_0016};
    for (int c = 0; c < 3; c++) begin
      valid = 1'b1;
      word  = w6;
      @(negedge clk);
      check("bp_gnt6",  64'(gnt),       64'd0);
      check("bp_valid", 64'(mem_valid), 64'd1);
      check("bp_data",  64'(mem_data),  64'h0000_0011);
      check("bp_last",  64'(mem_last),  64'd0);
      tick();
    end
    mem_ready = 1'b1;
    n = 0;
    g = 1'b0;
    while (!g && n < 20) begin
      offer(w6, 1'b1, g);
      n++;
    end
    check("bp_word6_granted", 64'(g), 64'd1);
    drain("bp", 100);

    // Flush after the first beat of A with B and C buffered.
    mem_ready = 1'b0;
    wa = 64'hAAAA_0001_AAAA_0000;
    wd = 64'hDDDD_0001_DDDD_0000;
    offer(wa, 1'b1, g);
    check("fl_gnt_a", 64'(g), 64'd1);
    offer(64'hBBBB_0001_BBBB_0000, 1'b0, g);
    check("fl_gnt_b", 64'(g), 64'd1);
    offer(64'hCCCC_0001_CCCC_0000, 1'b0, g);
    check("fl_gnt_c", 64'(g), 64'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    check("fl_a_lo_data", 64'(mem_data), 64'(wa[31:0]));
    tick();
    flush = 1'b1;
    valid = 1'b1;
    word  = wd;
    @(negedge clk);
    check("fl_gnt_in_flush", 64'(gnt),      64'd0);
    check("fl_a_hi_last",    64'(mem_last), 64'd1);
    tick();
    flush = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    check("fl_after_valid", 64'(mem_valid), 64'd0);
    check("fl_after_pending", 64'(exp_q.size()), 64'd0);
    tick();
    offer(wd, 1'b1, g);
    check("fl_gnt_d", 64'(g), 64'd1);
    drain("flush", 50);
    repeat (4) tick();

    // Reset in the middle of work, then the single-word timing again.
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) offer({32'hEEEE_0000, 32'(k)}, 1'b0, g);
    do_reset("midrst");
    single_word("post_rst", 64'h1111_2222_3333_4444);

`ifdef STORE_OP_SERIALIZER_PERF_EN
    do_reset("perf_rst");
    mem_ready = 1'b1;
    offer(64'h0000_00F1_0000_00F0, 1'b1, g);
    check("perf_gnt0", 64'(g), 64'd1);
    offer(64'h0000_00F3_0000_00F2, 1'b1, g);
    check("perf_gnt1", 64'(g), 64'd1);
    tick();
    mem_ready = 1'b0;
    repeat (3) tick();
    mem_ready = 1'b1;
    drain("perf", 50);
    check("perf_stall_cycles", 64'(stall_cycles), 64'd3);
    check("perf_words_done",   64'(words_done),   64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
